// File: rtl/i2s_sample_tx.sv
// Codec-side sample interface: emits the per-frame new_frame strobe, latches the returned
// sample, and serialises it as I2S (same mono sample on the left and right slots).
module i2s_sample_tx #(
    parameter int unsigned BCLK_HALF = 16,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                new_frame,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                busy
);

    localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned BitW = $clog2(2 * SLOT_BITS);
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(2 * SLOT_BITS - 1);
    localparam logic [BitW-1:0] SlotLen = BitW'(SLOT_BITS);

    typedef enum logic {StIdle, StRun} state_e;

    state_e              r_state,     w_state_nxt;
    logic [DivW-1:0]     r_div,       w_div_nxt;
    logic [BitW-1:0]     r_bit,       w_bit_nxt;
    logic                r_bclk,      w_bclk_nxt;
    logic                r_lrclk,     w_lrclk_nxt;
    logic                r_sdata,     w_sdata_nxt;
    logic                r_new_frame, w_new_frame_nxt;
    logic [SAMPLE_W-1:0] r_shadow,    w_shadow_nxt;

    logic                w_div_wrap;
    logic                w_bclk_fall;
    logic [BitW-1:0]     w_bit_inc;
    logic [BitW-1:0]     w_slot;
    logic                w_bit_data;

    // Data bit for the slot position we are about to enter; slot bit 0 is the I2S delay bit.
    always_comb begin
        w_div_wrap  = (r_div == DivLast);
        w_bclk_fall = w_div_wrap && r_bclk;
        w_bit_inc   = (r_bit == BitLast) ? '0 : r_bit + BitW'(1);
        w_slot      = (w_bit_inc >= SlotLen) ? w_bit_inc - SlotLen : w_bit_inc;
        w_bit_data  = 1'b0;
        for (int unsigned i = 0; i < SAMPLE_W; i++) begin
            if (w_slot == BitW'(SAMPLE_W - i)) begin
                w_bit_data = r_shadow[i];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_bit_nxt       = r_bit;
        w_bclk_nxt      = r_bclk;
        w_lrclk_nxt     = r_lrclk;
        w_sdata_nxt     = r_sdata;
        w_new_frame_nxt = 1'b0;
        // The sample is taken while new_frame is high, before music_player reacts to it.
        w_shadow_nxt    = r_new_frame ? sample_in : r_shadow;

        unique case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_nxt     = StRun;
                    w_div_nxt       = '0;
                    w_bit_nxt       = '0;
                    w_bclk_nxt      = 1'b0;
                    w_lrclk_nxt     = 1'b0;
                    w_sdata_nxt     = 1'b0;
                    w_new_frame_nxt = 1'b1;
                end
            end
            StRun: begin
                w_div_nxt = w_div_wrap ? '0 : r_div + DivW'(1);
                if (w_div_wrap) begin
                    w_bclk_nxt = ~r_bclk;
                end
                if (w_bclk_fall) begin
                    w_bit_nxt   = w_bit_inc;
                    w_lrclk_nxt = (w_bit_inc >= SlotLen);
                    w_sdata_nxt = w_bit_data;
                    // enable only matters at the frame boundary, so frames are never cut short.
                    if (w_bit_inc == '0) begin
                        if (enable) begin
                            w_new_frame_nxt = 1'b1;
                        end else begin
                            w_state_nxt = StIdle;
                            w_div_nxt   = '0;
                            w_bit_nxt   = '0;
                            w_bclk_nxt  = 1'b0;
                            w_lrclk_nxt = 1'b0;
                            w_sdata_nxt = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_div       <= '0;
            r_bit       <= '0;
            r_bclk      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_new_frame <= 1'b0;
            r_shadow    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_bclk      <= w_bclk_nxt;
            r_lrclk     <= w_lrclk_nxt;
            r_sdata     <= w_sdata_nxt;
            r_new_frame <= w_new_frame_nxt;
            r_shadow    <= w_shadow_nxt;
        end
    end

    assign new_frame = r_new_frame;
    assign bclk      = r_bclk;
    assign lrclk     = r_lrclk;
    assign sdata     = r_sdata;
    assign busy      = (r_state == StRun);

endmodule
